// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
package pc_pkg;
    localparam int unsigned PC_INC = 4;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_RAS,
        SEL_REDIR,
        SEL_TRAP
    } next_pc_sel_e;
endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack with saturating occupancy count.
// A full push overwrites the oldest entry; push+pop together replaces the top.
module ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_addr_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    top_q, top_d, waddr;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop_ok, we;

    assign pop_ok  = pop_i && (cnt_q != '0);
    assign empty_o = (cnt_q == '0);
    assign top_o   = mem_q[top_q];

    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        we    = 1'b0;
        waddr = top_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (push_i && pop_ok) begin
            we = 1'b1;
        end else if (push_i) begin
            we    = 1'b1;
            waddr = top_q + PW'(1);
            top_d = top_q + PW'(1);
            if (cnt_q != CW'(RAS_DEPTH))
                cnt_d = cnt_q + CW'(1);
        end else if (pop_ok) begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst)
            mem_q[waddr] <= push_addr_i;
    end
endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: trap > redirect > RAS return > stall > PC+4.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(DEF_TRAP_VEC),
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             trap,
    input  logic             call_push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             ret_pop,
    output logic             ras_empty,
    output logic             misalign
);
    logic [WIDTH-1:0] pc_q, pc_d, ras_top;
    logic             fv_q, mis_q, mis_d;
    logic             ctl_ok, push_go, pop_go;
    next_pc_sel_e     sel;

    // Call/return hints only count when the fetch is accepted and not flushed.
    assign ctl_ok  = fetch_ready && !trap && !redirect_valid;
    assign push_go = call_push && ctl_ok;
    assign pop_go  = ret_pop && ctl_ok && !ras_empty;

    ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (trap),
        .push_i      (push_go),
        .pop_i       (pop_go),
        .push_addr_i (push_addr),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );

    // The first cycle out of reset holds RESET_VEC so it is actually fetched.
    always_comb begin
        sel   = SEL_SEQ;
        mis_d = 1'b0;
        if (trap) begin
            sel = SEL_TRAP;
        end else if (redirect_valid) begin
            if (redirect_target[1]) begin
                sel   = SEL_TRAP;
                mis_d = 1'b1;
            end else begin
                sel = SEL_REDIR;
            end
        end else if (pop_go) begin
            sel = SEL_RAS;
        end else if (!fv_q || !fetch_ready) begin
            sel = SEL_HOLD;
        end
    end

    always_comb begin
        case (sel)
            SEL_TRAP:  pc_d = TRAP_VEC;
            SEL_REDIR: pc_d = {redirect_target[WIDTH-1:2], 2'b00};
            SEL_RAS:   pc_d = {ras_top[WIDTH-1:2], 2'b00};
            SEL_SEQ:   pc_d = pc_q + WIDTH'(PC_INC);
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            fv_q  <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            fv_q  <= 1'b1;
            mis_q <= mis_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = fv_q;
    assign misalign    = mis_q;
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit instance for the main scenarios and
// an 8-bit instance for wraparound and trap-vector truncation.
module tb_pc_gen;
    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] tgt;
        logic        trap, push;
        logic [31:0] pa;
        logic        pop;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic        fv, mis, emp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, rdy32, rv32, trap32, push32, pop32;
    logic [31:0] tgt32, pa32, pc32;
    logic        fv32, emp32, mis32;

    logic        rst8, rdy8, rv8, trap8, push8, pop8;
    logic [7:0]  tgt8, pa8, pc8;
    logic        fv8, emp8, mis8;

    int   n_pass = 0;
    int   n_tot  = 0;
    exp_t sb[$];

    pc_gen dut32 (
        .clk(clk), .rst(rst32), .fetch_ready(rdy32), .fetch_valid(fv32), .pc(pc32),
        .redirect_valid(rv32), .redirect_target(tgt32), .trap(trap32),
        .call_push(push32), .push_addr(pa32), .ret_pop(pop32),
        .ras_empty(emp32), .misalign(mis32)
    );

    pc_gen #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .fetch_ready(rdy8), .fetch_valid(fv8), .pc(pc8),
        .redirect_valid(rv8), .redirect_target(tgt8), .trap(trap8),
        .call_push(push8), .push_addr(pa8), .ret_pop(pop8),
        .ras_empty(emp8), .misalign(mis8)
    );

    function automatic stim_t mk_s(logic r, logic rdy, logic rv, logic [31:0] tgt,
                                   logic tr, logic pu, logic [31:0] pa, logic po);
        stim_t s;
        s.rst = r; s.rdy = rdy; s.rv = rv; s.tgt = tgt;
        s.trap = tr; s.push = pu; s.pa = pa; s.pop = po;
        return s;
    endfunction

    function automatic exp_t mk_x(logic [31:0] p, logic fv, logic mis, logic emp);
        exp_t e;
        e.pc = p; e.fv = fv; e.mis = mis; e.emp = emp;
        return e;
    endfunction

    task automatic drive32(input stim_t s);
        rst32 = s.rst; rdy32 = s.rdy; rv32 = s.rv; tgt32 = s.tgt;
        trap32 = s.trap; push32 = s.push; pa32 = s.pa; pop32 = s.pop;
    endtask

    task automatic drive8(input stim_t s);
        rst8 = s.rst; rdy8 = s.rdy; rv8 = s.rv; tgt8 = s.tgt[7:0];
        trap8 = s.trap; push8 = s.push; pa8 = s.pa[7:0]; pop8 = s.pop;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        st.push_back(mk_s(1, 1, 0, 0, 0, 0, 0, 0));    ex.push_back(mk_x(32'h0, 0, 0, 1));
        st.push_back(mk_s(1, 0, 1, 32'h40, 0, 0, 0, 0)); ex.push_back(mk_x(32'h0, 0, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0));    ex.push_back(mk_x(32'h0, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0));    ex.push_back(mk_x(32'h4, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0));    ex.push_back(mk_x(32'h8, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0));    ex.push_back(mk_x(32'hC, 1, 0, 1));
        // reset during a stall with a live RAS entry
        st.push_back(mk_s(0, 1, 0, 0, 0, 1, 32'h10, 0)); ex.push_back(mk_x(32'h10, 1, 0, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0));    ex.push_back(mk_x(32'h10, 1, 0, 0));
        st.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0));    ex.push_back(mk_x(32'h0, 0, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0));    ex.push_back(mk_x(32'h0, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1));    ex.push_back(mk_x(32'h4, 1, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            drive32(st[i]); sb.push_back(ex[i]); tick(); e = sb.pop_front();
            n_tot++; if (pc32 !== e.pc) $display("FAIL reset[%0d] pc got %h want %h", i, pc32, e.pc); else n_pass++;
            n_tot++; if (fv32 !== e.fv) $display("FAIL reset[%0d] fetch_valid got %b want %b", i, fv32, e.fv); else n_pass++;
            n_tot++; if (mis32 !== e.mis) $display("FAIL reset[%0d] misalign got %b want %b", i, mis32, e.mis); else n_pass++;
            n_tot++; if (emp32 !== e.emp) $display("FAIL reset[%0d] ras_empty got %b want %b", i, emp32, e.emp); else n_pass++;
        end
    endtask

    task automatic test_stall();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        st.push_back(mk_s(1, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_x(32'h0, 0, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_x(32'h0, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_x(32'h4, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_x(32'h8, 1, 0, 1));
        for (int k = 0; k < 3; k++) begin
            st.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_x(32'h8, 1, 0, 1));
        end
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0));      ex.push_back(mk_x(32'hC, 1, 0, 1));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0));      ex.push_back(mk_x(32'hC, 1, 0, 1));
        st.push_back(mk_s(0, 0, 1, 32'h40, 0, 0, 0, 0)); ex.push_back(mk_x(32'h40, 1, 0, 1));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0));      ex.push_back(mk_x(32'h40, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0));      ex.push_back(mk_x(32'h44, 1, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            drive32(st[i]); sb.push_back(ex[i]); tick(); e = sb.pop_front();
            n_tot++; if (pc32 !== e.pc) $display("FAIL stall[%0d] pc got %h want %h", i, pc32, e.pc); else n_pass++;
            n_tot++; if (fv32 !== e.fv) $display("FAIL stall[%0d] fetch_valid got %b want %b", i, fv32, e.fv); else n_pass++;
        end
    endtask

    task automatic test_misalign();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        st.push_back(mk_s(0, 1, 1, 32'h42, 0, 0, 0, 0)); ex.push_back(mk_x(32'h100, 1, 1, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0));      ex.push_back(mk_x(32'h104, 1, 0, 1));
        st.push_back(mk_s(0, 0, 1, 32'h42, 1, 0, 0, 0)); ex.push_back(mk_x(32'h100, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0));      ex.push_back(mk_x(32'h104, 1, 0, 1));
        st.push_back(mk_s(0, 1, 1, 32'h80, 0, 0, 0, 0)); ex.push_back(mk_x(32'h80, 1, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            drive32(st[i]); sb.push_back(ex[i]); tick(); e = sb.pop_front();
            n_tot++; if (pc32 !== e.pc) $display("FAIL misalign[%0d] pc got %h want %h", i, pc32, e.pc); else n_pass++;
            n_tot++; if (mis32 !== e.mis) $display("FAIL misalign[%0d] misalign got %b want %b", i, mis32, e.mis); else n_pass++;
        end
    endtask

    task automatic test_ras();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        st.push_back(mk_s(0, 1, 0, 0, 1, 0, 0, 0));           ex.push_back(mk_x(32'h100, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 1, 32'h10, 0));      ex.push_back(mk_x(32'h104, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 1, 32'h20, 0));      ex.push_back(mk_x(32'h108, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1));           ex.push_back(mk_x(32'h20, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1));           ex.push_back(mk_x(32'h10, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1));           ex.push_back(mk_x(32'h14, 1, 0, 1));
        // push suppressed by a redirect; redirect leaves stored entries alone
        st.push_back(mk_s(0, 1, 1, 32'h200, 0, 1, 32'h99, 0)); ex.push_back(mk_x(32'h200, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1));           ex.push_back(mk_x(32'h204, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 1, 32'h10, 0));      ex.push_back(mk_x(32'h208, 1, 0, 0));
        st.push_back(mk_s(0, 1, 1, 32'h300, 0, 0, 0, 1));     ex.push_back(mk_x(32'h300, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1));           ex.push_back(mk_x(32'h10, 1, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            drive32(st[i]); sb.push_back(ex[i]); tick(); e = sb.pop_front();
            n_tot++; if (pc32 !== e.pc) $display("FAIL ras[%0d] pc got %h want %h", i, pc32, e.pc); else n_pass++;
            n_tot++; if (emp32 !== e.emp) $display("FAIL ras[%0d] ras_empty got %b want %b", i, emp32, e.emp); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        st.push_back(mk_s(0, 1, 0, 0, 1, 0, 0, 0)); ex.push_back(mk_x(32'h100, 1, 0, 1));
        for (int k = 1; k <= 5; k++) begin
            st.push_back(mk_s(0, 1, 0, 0, 0, 1, 32'(k * 16), 0));
            ex.push_back(mk_x(32'(32'h100 + k * 4), 1, 0, 0));
        end
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(mk_x(32'h50, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(mk_x(32'h40, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(mk_x(32'h30, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(mk_x(32'h20, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(mk_x(32'h24, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 1, 32'h10, 0)); ex.push_back(mk_x(32'h28, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 1, 32'h20, 0)); ex.push_back(mk_x(32'h2C, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 1, 32'h30, 0)); ex.push_back(mk_x(32'h30, 1, 0, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 1));      ex.push_back(mk_x(32'h30, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 1, 32'h80, 1)); ex.push_back(mk_x(32'h30, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1));      ex.push_back(mk_x(32'h80, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1));      ex.push_back(mk_x(32'h20, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1));      ex.push_back(mk_x(32'h10, 1, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            drive32(st[i]); sb.push_back(ex[i]); tick(); e = sb.pop_front();
            n_tot++; if (pc32 !== e.pc) $display("FAIL overflow[%0d] pc got %h want %h", i, pc32, e.pc); else n_pass++;
            n_tot++; if (emp32 !== e.emp) $display("FAIL overflow[%0d] ras_empty got %b want %b", i, emp32, e.emp); else n_pass++;
        end
    endtask

    task automatic test_wrap_trap();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        drive32(mk_s(1, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(mk_s(1, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_x(32'h0, 0, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_x(32'h0, 1, 0, 1));
        for (int k = 1; k <= 63; k++) begin
            st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(mk_x(32'(k * 4), 1, 0, 1));
        end
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 0));      ex.push_back(mk_x(32'h00, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 1, 32'h10, 0)); ex.push_back(mk_x(32'h04, 1, 0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 1, 0, 0, 0));      ex.push_back(mk_x(32'h00, 1, 0, 1));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0, 0, 1));      ex.push_back(mk_x(32'h04, 1, 0, 1));
        st.push_back(mk_s(0, 1, 1, 32'h42, 0, 0, 0, 0)); ex.push_back(mk_x(32'h00, 1, 1, 1));
        for (int i = 0; i < st.size(); i++) begin
            drive8(st[i]); sb.push_back(ex[i]); tick(); e = sb.pop_front();
            n_tot++; if (pc8 !== e.pc[7:0]) $display("FAIL wrap[%0d] pc got %h want %h", i, pc8, e.pc[7:0]); else n_pass++;
            n_tot++; if (fv8 !== e.fv) $display("FAIL wrap[%0d] fetch_valid got %b want %b", i, fv8, e.fv); else n_pass++;
            n_tot++; if (mis8 !== e.mis) $display("FAIL wrap[%0d] misalign got %b want %b", i, mis8, e.mis); else n_pass++;
            n_tot++; if (emp8 !== e.emp) $display("FAIL wrap[%0d] ras_empty got %b want %b", i, emp8, e.emp); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        drive32(mk_s(1, 0, 0, 0, 0, 0, 0, 0));
        drive8(mk_s(1, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_stall();
        test_misalign();
        test_ras();
        test_overflow();
        test_wrap_trap();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
